psk_mapper: RTL and testbench

PSK_MAPPER -- requirements
Module: psk_mapper

---
 rtl/psk_pkg.sv | 17 +
 rtl/psk_const_lut.sv | 33 +++
 rtl/psk_mapper.sv | 123 ++++++++++++
 tb/tb_psk_mapper.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psk_pkg.sv
// Shared PSK definitions: FSM state encoding and default constellation amplitudes.
// Both the mapper and the demapper import this package.
package psk_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } psk_state_t;

   localparam int IQ_W_DEF     = 12;
   localparam int AMP_BPSK_DEF = 2047;
   localparam int AMP_QPSK_DEF = 1448;

   // Wide enough for rep_cnt with SPS up to 255.
   localparam int REP_W = 8;

endpackage

// File: rtl/psk_const_lut.sv
// Combinational constellation map from symbol bits and the BPSK flag to an (I,Q) pair.
// The amplitudes are the exact parameter values, sign-extended to IQ_W.
module psk_const_lut
   import psk_pkg::*;
#(
   parameter int IQ_W     = IQ_W_DEF,
   parameter int AMP_BPSK = AMP_BPSK_DEF,
   parameter int AMP_QPSK = AMP_QPSK_DEF
) (
   input  logic [1:0]             bits,
   input  logic                   is_bpsk,
   output logic signed [IQ_W-1:0] i_val,
   output logic signed [IQ_W-1:0] q_val
);

   localparam logic signed [IQ_W-1:0] B_POS = IQ_W'(AMP_BPSK);
   localparam logic signed [IQ_W-1:0] B_NEG = IQ_W'(-AMP_BPSK);
   localparam logic signed [IQ_W-1:0] Q_POS = IQ_W'(AMP_QPSK);
   localparam logic signed [IQ_W-1:0] Q_NEG = IQ_W'(-AMP_QPSK);

   // BPSK uses bit0 on I only; QPSK takes I from bits[1] and Q from bits[0].
   always_comb begin
      i_val = '0;
      q_val = '0;
      if (is_bpsk) begin
         i_val = bits[0] ? B_NEG : B_POS;
      end else begin
         i_val = bits[1] ? Q_NEG : Q_POS;
         q_val = bits[0] ? Q_NEG : Q_POS;
      end
   end

endmodule

// File: rtl/psk_mapper.sv
// BPSK/QPSK symbol mapper: takes one symbol per AXIS beat and repeats the mapped (I,Q)
// pair SPS times on the master side, tracking packets with a two-state FSM.
module psk_mapper
   import psk_pkg::*;
#(
   parameter int BYTES    = 1,
   parameter int SPS      = 1,
   parameter int IQ_W     = IQ_W_DEF,
   parameter int AMP_BPSK = AMP_BPSK_DEF,
   parameter int AMP_QPSK = AMP_QPSK_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [BYTES*8-1:0]     s_tdata,
   input  logic                   s_tvalid,
   output logic                   s_tready,
   input  logic                   s_tlast,
   input  logic                   s_tuser,
   output logic signed [IQ_W-1:0] m_i,
   output logic signed [IQ_W-1:0] m_q,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic                   m_tlast,
   output logic                   sym_strobe,
   output logic                   underrun,
   output logic [15:0]            pkt_cnt,
   output psk_state_t             fsm_state
);

   localparam logic [REP_W-1:0] LAST_REP = REP_W'(SPS - 1);

   psk_state_t             state;
   logic                   full;
   logic                   hold_last;
   logic [REP_W-1:0]       rep_cnt;
   logic signed [IQ_W-1:0] hold_i;
   logic signed [IQ_W-1:0] hold_q;
   logic signed [IQ_W-1:0] lut_i;
   logic signed [IQ_W-1:0] lut_q;
   logic [15:0]            pkt_q;
   logic                   underrun_q;

   logic last_rep;
   logic m_hs;
   logic fin;
   logic ready_int;
   logic s_hs;
   logic unused_tdata;

   assign unused_tdata = ^s_tdata[BYTES*8-1:2];

   psk_const_lut #(
      .IQ_W     (IQ_W),
      .AMP_BPSK (AMP_BPSK),
      .AMP_QPSK (AMP_QPSK)
   ) u_lut (
      .bits    (s_tdata[1:0]),
      .is_bpsk (s_tuser),
      .i_val   (lut_i),
      .q_val   (lut_q)
   );

   // Handshakes: a beat transfers on a side in any cycle where valid and ready are both
   // high at the rising edge of clk; valid never waits on ready, and the master side holds
   // data stable while valid is high and ready is low. s_tready also opens on the final
   // accepted repetition so back-to-back symbols flow without a bubble.
   assign last_rep  = (rep_cnt == LAST_REP);
   assign m_hs      = full && m_tready;
   assign fin       = m_hs && last_rep;
   assign ready_int = !full || fin;
   assign s_hs      = s_tvalid && ready_int;

   // Outputs are gated by rst_n so they read zero for the whole reset interval.
   assign s_tready   = rst_n && ready_int;
   assign m_tvalid   = rst_n && full;
   assign m_i        = m_tvalid ? hold_i : '0;
   assign m_q        = m_tvalid ? hold_q : '0;
   assign m_tlast    = m_tvalid && hold_last && last_rep;
   assign sym_strobe = m_tvalid && (rep_cnt == '0);
   assign underrun   = rst_n && underrun_q;
   assign pkt_cnt    = rst_n ? pkt_q : '0;
   assign fsm_state  = state;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         full       <= 1'b0;
         hold_last  <= 1'b0;
         rep_cnt    <= '0;
         hold_i     <= '0;
         hold_q     <= '0;
         pkt_q      <= '0;
         underrun_q <= 1'b0;
      end else begin
         underrun_q <= (state == ACTIVE) && fin && !hold_last && !s_tvalid;

         if (s_hs) begin
            full      <= 1'b1;
            hold_i    <= lut_i;
            hold_q    <= lut_q;
            hold_last <= s_tlast;
            rep_cnt   <= '0;
         end else if (fin) begin
            full    <= 1'b0;
            rep_cnt <= '0;
         end else if (m_hs) begin
            rep_cnt <= rep_cnt + 1'b1;
         end

         if (fin && hold_last) begin
            pkt_q <= pkt_q + 16'd1;
         end

         // A new symbol taken in the same cycle as the tlast repetition opens the next packet.
         if (state == IDLE) begin
            if (s_hs) state <= ACTIVE;
         end else begin
            if (fin && hold_last && !s_hs) state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_psk_mapper.sv
// Bench for psk_mapper: three instances (SPS = 1, 2, 4) share the stimulus; one is selected
// per test and checked against a symbol-level reference queue plus directed cycle checks.
module tb_psk_mapper;
   import psk_pkg::*;

   localparam int IQ_W  = 12;
   localparam int AMP_B = 2047;
   localparam int AMP_Q = 1448;
   localparam int N_DUT = 3;

   typedef logic [2*IQ_W:0] exp_t;  // {last, i, q}

   // clock / reset
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [7:0] s_tdata;
   logic       s_tvalid, s_tlast, s_tuser, m_tready;
   logic [1:0] sel;

   logic            s_tready_a   [N_DUT];
   logic [IQ_W-1:0] m_i_a        [N_DUT];
   logic [IQ_W-1:0] m_q_a        [N_DUT];
   logic            m_tvalid_a   [N_DUT];
   logic            m_tlast_a    [N_DUT];
   logic            sym_strobe_a [N_DUT];
   logic            underrun_a   [N_DUT];
   logic [15:0]     pkt_cnt_a    [N_DUT];
   psk_state_t      fsm_a        [N_DUT];

   for (genvar g = 0; g < N_DUT; g++) begin : g_dut
      psk_mapper #(
         .BYTES    (1),
         .SPS      (g == 0 ? 1 : (g == 1 ? 2 : 4)),
         .IQ_W     (IQ_W),
         .AMP_BPSK (AMP_B),
         .AMP_QPSK (AMP_Q)
      ) dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .s_tdata    (s_tdata),
         .s_tvalid   (s_tvalid),
         .s_tready   (s_tready_a[g]),
         .s_tlast    (s_tlast),
         .s_tuser    (s_tuser),
         .m_i        (m_i_a[g]),
         .m_q        (m_q_a[g]),
         .m_tvalid   (m_tvalid_a[g]),
         .m_tready   (m_tready),
         .m_tlast    (m_tlast_a[g]),
         .sym_strobe (sym_strobe_a[g]),
         .underrun   (underrun_a[g]),
         .pkt_cnt    (pkt_cnt_a[g]),
         .fsm_state  (fsm_a[g])
      );
   end

   logic            cur_s_tready, cur_m_tvalid, cur_m_tlast, cur_sym_strobe, cur_underrun;
   logic [IQ_W-1:0] cur_m_i, cur_m_q;
   logic [15:0]     cur_pkt_cnt;
   psk_state_t      cur_fsm;

   always_comb begin
      cur_s_tready   = s_tready_a[sel];
      cur_m_tvalid   = m_tvalid_a[sel];
      cur_m_tlast    = m_tlast_a[sel];
      cur_sym_strobe = sym_strobe_a[sel];
      cur_underrun   = underrun_a[sel];
      cur_m_i        = m_i_a[sel];
      cur_m_q        = m_q_a[sel];
      cur_pkt_cnt    = pkt_cnt_a[sel];
      cur_fsm        = fsm_a[sel];
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int sps_of(input logic [1:0] s);
      return (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
   endfunction

   function automatic logic [IQ_W-1:0] iq(input int v);
      return IQ_W'(v);
   endfunction

   // Reference mapping straight from the constellation rules.
   function automatic exp_t model_sym(input logic [7:0] d, input logic bpsk, input logic last);
      int i_v, q_v;
      if (bpsk) begin
         i_v = d[0] ? -AMP_B : AMP_B;
         q_v = 0;
      end else begin
         i_v = d[1] ? -AMP_Q : AMP_Q;
         q_v = d[0] ? -AMP_Q : AMP_Q;
      end
      return {last, iq(i_v), iq(q_v)};
   endfunction

   // scoreboard
   exp_t            exp_q[$];
   logic [15:0]     exp_pkt;
   logic            stall_prev;
   logic [IQ_W-1:0] stall_i, stall_q;

   always @(negedge clk) begin : mon
      exp_t e;
      int   sps;
      if (!rst_n) begin
         exp_q.delete();
         exp_pkt    = 16'd0;
         stall_prev = 1'b0;
         check_eq("reset_outputs", {cur_s_tready, cur_m_tvalid, cur_m_tlast, cur_sym_strobe,
                  cur_underrun, cur_m_i, cur_m_q, cur_pkt_cnt}, 64'd0);
      end else begin
         check_eq("pkt_cnt", cur_pkt_cnt, exp_pkt);
         if (stall_prev)
            check_eq("stall_hold", {cur_m_tvalid, cur_m_i, cur_m_q}, {1'b1, stall_i, stall_q});
         if (cur_m_tvalid && m_tready) begin
            check_eq("out_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check_eq("out_sample", {cur_m_tlast, cur_m_i, cur_m_q}, e);
               if (e[2*IQ_W]) exp_pkt = exp_pkt + 16'd1;
            end
         end
         if (s_tvalid && cur_s_tready) begin
            sps = sps_of(sel);
            for (int r = 0; r < sps; r++)
               exp_q.push_back(model_sym(s_tdata, s_tuser, s_tlast && (r == sps - 1)));
         end
         stall_prev = cur_m_tvalid && !m_tready;
         stall_i    = cur_m_i;
         stall_q    = cur_m_q;
      end
   end

   // driver
   int tready_mode;  // 0: always ready, 1: toggle 1010, 2: random
   int tr_phase;
   int ur_seen;

   task automatic cycle(input logic v, input logic [7:0] d, input logic u, input logic l);
      @(posedge clk);
      #1;
      s_tvalid = v;
      s_tdata  = d;
      s_tuser  = u;
      s_tlast  = l;
      case (tready_mode)
         0:       m_tready = 1'b1;
         1:       m_tready = (tr_phase % 2) == 0;
         default: m_tready = $urandom_range(0, 3) != 0;
      endcase
      tr_phase++;
      @(negedge clk);
      #1;
      if (cur_underrun) ur_seen++;
   endtask

   task automatic idle();
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic send_sym(input logic [1:0] bits, input logic bpsk, input logic last);
      logic [7:0] d;
      int         n;
      d = {6'($urandom), bits};
      n = 0;
      do begin
         cycle(1'b1, d, bpsk, last);
         n++;
      end while (!cur_s_tready && n < 200);
      if (!cur_s_tready) check_eq("send_timeout", cur_s_tready, 1);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || cur_m_tvalid) && n < 400) begin
         idle();
         n++;
      end
      check_eq("drain_done", {exp_q.size() != 0, cur_m_tvalid}, 0);
   endtask

   task automatic do_reset(input logic [1:0] s);
      @(posedge clk);
      #1;
      rst_n    = 1'b0;
      sel      = s;
      s_tvalid = 1'b0;
      tr_phase = 0;
      ur_seen  = 0;
      repeat (3) idle();
      check_eq("reset_fsm", cur_fsm, IDLE);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      #1;
   endtask

   initial begin : main
      int n_last;
      logic b;
      rst_n = 1'b0; sel = 2'd0; s_tvalid = 1'b0; s_tdata = 8'h00; s_tuser = 1'b0;
      s_tlast = 1'b0; m_tready = 1'b0; tready_mode = 0; tr_phase = 0; ur_seen = 0;

      // SPS=1 BPSK 0,1,1(last) back to back
      do_reset(2'd0);
      cycle(1'b1, 8'($urandom) & 8'hFE, 1'b1, 1'b0);
      check_eq("t1_rdy0", cur_s_tready, 1);
      cycle(1'b1, 8'($urandom) | 8'h01, 1'b1, 1'b0);
      check_eq("t1_i0", cur_m_i, iq(AMP_B));
      check_eq("t1_q0", cur_m_q, 0);
      check_eq("t1_rdy1", cur_s_tready, 1);
      cycle(1'b1, 8'($urandom) | 8'h01, 1'b1, 1'b1);
      check_eq("t1_i1", cur_m_i, iq(-AMP_B));
      check_eq("t1_last1", cur_m_tlast, 0);
      idle();
      check_eq("t1_i2", cur_m_i, iq(-AMP_B));
      check_eq("t1_q2", cur_m_q, 0);
      check_eq("t1_last2", cur_m_tlast, 1);
      idle();
      check_eq("t1_vld_end", cur_m_tvalid, 0);
      check_eq("t1_pkt", cur_pkt_cnt, 1);
      check_eq("t1_fsm", cur_fsm, IDLE);

      // SPS=4 QPSK 00 then 11(last)
      do_reset(2'd2);
      cycle(1'b1, 8'($urandom) & 8'hFC, 1'b0, 1'b0);
      check_eq("t2_rdy_empty", cur_s_tready, 1);
      for (int c = 1; c <= 8; c++) begin
         cycle(c <= 4, 8'($urandom) | 8'h03, 1'b0, 1'b1);
         check_eq("t2_i", cur_m_i, iq(c <= 4 ? AMP_Q : -AMP_Q));
         check_eq("t2_q", cur_m_q, iq(c <= 4 ? AMP_Q : -AMP_Q));
         check_eq("t2_strobe", cur_sym_strobe, (c == 1 || c == 5));
         check_eq("t2_rdy", cur_s_tready, (c == 4 || c == 8));
         check_eq("t2_last", cur_m_tlast, (c == 8));
      end
      idle();
      check_eq("t2_vld_end", cur_m_tvalid, 0);
      check_eq("t2_pkt", cur_pkt_cnt, 1);

      // SPS=2 gap after the 2nd of 5 symbols
      do_reset(2'd1);
      send_sym(2'($urandom), 1'b1, 1'b0);
      send_sym(2'($urandom), 1'b1, 1'b0);
      for (int g = 0; g < 6; g++) begin
         idle();
         if (g >= 3) begin
            check_eq("t3_gap_vld", cur_m_tvalid, 0);
            check_eq("t3_gap_fsm", cur_fsm, ACTIVE);
         end
      end
      send_sym(2'($urandom), 1'b1, 1'b0);
      send_sym(2'($urandom), 1'b1, 1'b0);
      send_sym(2'($urandom), 1'b1, 1'b1);
      drain();
      check_eq("t3_underrun_once", ur_seen, 1);
      check_eq("t3_pkt", cur_pkt_cnt, 1);

      // SPS=2 with m_tready toggling 1010
      do_reset(2'd1);
      tready_mode = 1;
      for (int k = 0; k < 6; k++) send_sym(2'($urandom), 1'($urandom), k == 5);
      drain();
      check_eq("t4_pkt", cur_pkt_cnt, 1);
      tready_mode = 0;

      // reset mid-packet, then a fresh one-symbol packet
      do_reset(2'd0);
      send_sym(2'($urandom), 1'b1, 1'b0);
      send_sym(2'($urandom), 1'b1, 1'b0);
      do_reset(2'd0);
      b = 1'($urandom);
      send_sym({1'b0, b}, 1'b1, 1'b1);
      idle();
      check_eq("t5_vld", cur_m_tvalid, 1);
      check_eq("t5_last", cur_m_tlast, 1);
      check_eq("t5_i", cur_m_i, iq(b ? -AMP_B : AMP_B));
      idle();
      check_eq("t5_pkt", cur_pkt_cnt, 1);

      // packet counter wrap
      do_reset(2'd0);
      for (int k = 0; k < 65535; k++) send_sym(2'($urandom), 1'b1, 1'b1);
      drain();
      check_eq("t6_pkt_max", cur_pkt_cnt, 16'hFFFF);
      send_sym(2'($urandom), 1'b0, 1'b1);
      drain();
      check_eq("t6_pkt_wrap", cur_pkt_cnt, 0);

      // randomized traffic on every instance
      for (int r = 0; r < N_DUT; r++) begin
         do_reset(2'(r));
         tready_mode = 2;
         n_last = 0;
         for (int k = 0; k < 30; k++) begin
            logic l;
            l = (k == 29) || ($urandom_range(0, 3) == 0);
            if (l) n_last++;
            repeat ($urandom_range(0, 2)) idle();
            send_sym(2'($urandom), 1'($urandom), l);
         end
         drain();
         check_eq("t7_pkt", cur_pkt_cnt, 16'(n_last));
         tready_mode = 0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #10000000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
